// File: rtl/sram_mem_controller.sv
// Word load/store controller splitting each 32-bit request into two 16-bit async SRAM accesses.
// Optional `SRAM_CTRL_RANGE_CHECK_EN adds addr_error and rejects out-of-window addresses.
module sram_mem_controller #(
  parameter int ADDR_BASE     = 1024,
  parameter int SRAM_ADDR_W   = 18,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MEM_R_EN,
  input  logic                   MEM_W_EN,
  input  logic [31:0]            address,
  input  logic [31:0]            storeValue,
  output logic [31:0]            memoryData,
  output logic                   ready,
  inout  wire  [15:0]            SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N
`ifdef SRAM_CTRL_RANGE_CHECK_EN
  ,
  output logic                   addr_error
`endif
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;

  localparam int         WORD_W = SRAM_ADDR_W - 1;
  localparam logic [3:0] LAST   = 4'(ACCESS_CYCLES - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [31:0]         store_q, store_d;
  logic                wr_q, wr_d;
  logic [15:0]         low_q, low_d;
  logic [31:0]         mem_data_q, mem_data_d;
  logic                err_q, err_d;

  logic [31:0] off;
  logic        req;
  logic        last;
  logic        bad_addr;
  logic        phase;
  logic        dq_oe;
  logic [15:0] dq_out;

  assign off  = address - 32'(ADDR_BASE);
  assign req  = MEM_R_EN | MEM_W_EN;
  assign last = (cnt_q == LAST);

`ifdef SRAM_CTRL_RANGE_CHECK_EN
  assign bad_addr   = (address < 32'(ADDR_BASE)) || (off[31:SRAM_ADDR_W+1] != '0);
  assign addr_error = (state_q == DONE) && err_q;
`else
  assign bad_addr   = 1'b0;
`endif

  // NOTE: every *_d gets its current value first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    store_d    = store_q;
    wr_d       = wr_q;
    low_d      = low_q;
    mem_data_d = mem_data_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          // A simultaneous read and write is treated as a write.
          wr_d    = MEM_W_EN;
          word_d  = off[SRAM_ADDR_W:2];
          store_d = storeValue;
          cnt_d   = '0;
          err_d   = bad_addr;
          if (bad_addr) begin
            state_d = DONE;
            if (!MEM_W_EN) mem_data_d = '0;
          end else begin
            state_d = LOW;
          end
        end
      end
      LOW: begin
        if (last) begin
          if (!wr_q) low_d = SRAM_DQ;
          cnt_d   = '0;
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HIGH: begin
        if (last) begin
          if (!wr_q) mem_data_d = {SRAM_DQ, low_q};
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the captured request
  // fields (word/store/low) are not reset since they are always loaded before use.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      mem_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      mem_data_q <= mem_data_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    word_q  <= word_d;
    store_q <= store_d;
    low_q   <= low_d;
  end

  assign phase = (state_q == LOW) || (state_q == HIGH);

  always_comb begin
    ready     = ((state_q == IDLE) && !req) || (state_q == DONE);
    SRAM_ADDR = phase ? {word_q, (state_q == HIGH)} : '0;
    // WE_N releases on the final cycle of each half so data outlives the strobe.
    SRAM_WE_N = !(phase && wr_q && ((ACCESS_CYCLES == 1) || !last));
    SRAM_OE_N = !(phase && !wr_q);
    dq_oe     = phase && wr_q;
    dq_out    = (state_q == HIGH) ? store_q[31:16] : store_q[15:0];
  end

  assign SRAM_DQ    = dq_oe ? dq_out : 16'hzzzz;
  assign memoryData = mem_data_q;
  assign SRAM_CE_N  = 1'b0;
  assign SRAM_UB_N  = 1'b0;
  assign SRAM_LB_N  = 1'b0;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Scoreboard bench for sram_mem_controller with a behavioural async SRAM on the data bus.
// Define SRAM_CTRL_RANGE_CHECK_EN for both files to exercise the address window check.
module tb_sram_mem_controller;

  localparam int AC        = 2;
  localparam int ADDR_BASE = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] address, storeValue;
  logic [31:0] memoryData;
  logic        ready;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;
`ifdef SRAM_CTRL_RANGE_CHECK_EN
  logic        addr_error;
`endif

  int checks   = 0;
  int failures = 0;

  logic [15:0] sram [0:255];
  logic        tb_drive;
  logic [33:0] wr_sb[$];
  logic [31:0] rd_sb[$];
  logic [31:0] shadow [int];
  logic [31:0] exp_mem_data;

  sram_mem_controller #(.ADDR_BASE(ADDR_BASE), .SRAM_ADDR_W(18), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .address(address), .storeValue(storeValue), .memoryData(memoryData), .ready(ready),
    .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
`ifdef SRAM_CTRL_RANGE_CHECK_EN
    , .addr_error(addr_error)
`endif
  );

  always #5 clk = ~clk;

  // SRAM model: drives on OE_N, stores on WE_N; tb_drive lets the bench probe bus release.
  assign SRAM_DQ = (!SRAM_OE_N) ? sram[SRAM_ADDR[7:0]] : (tb_drive ? 16'h5A5A : 16'hzzzz);

  always @(posedge clk) begin
    if (SRAM_WE_N === 1'b0) sram[SRAM_ADDR[7:0]] <= SRAM_DQ;
  end

  // Each low WE_N cycle must match the next expected half-word write.
  always @(negedge clk) begin
    if (!rst && SRAM_WE_N === 1'b0) begin
      logic [33:0] exp;
      checks++;
      if (wr_sb.size() == 0) begin
        failures++;
        $display("FAIL wr_strobe unexpected: addr=%0h dq=%h, none expected", SRAM_ADDR, SRAM_DQ);
      end else begin
        exp = wr_sb.pop_front();
        if ({SRAM_ADDR, SRAM_DQ} !== exp || SRAM_OE_N !== 1'b1) begin
          failures++;
          $display("FAIL wr_strobe: addr=%0h dq=%h oe_n=%b, expected addr=%0h dq=%h oe_n=1",
                   SRAM_ADDR, SRAM_DQ, SRAM_OE_N, exp[33:16], exp[15:0]);
        end
      end
    end
  end

  task automatic do_req(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input string name);
    logic [31:0] off;
    logic [15:0] word;
    logic [31:0] exp_rd;
    bit          bad, done, strobe_bad;
    int          low_cnt, exp_low;
    off = a - ADDR_BASE;
    word = off[17:2];
`ifdef SRAM_CTRL_RANGE_CHECK_EN
    bad = (a < ADDR_BASE) || (off[31:19] != 0);
`else
    bad = 1'b0;
`endif
    exp_low = bad ? 1 : 1 + 2 * AC;
    exp_rd  = 32'h0;
    @(negedge clk);
    MEM_R_EN = r; MEM_W_EN = w; address = a; storeValue = d;
    if (w) begin
      if (!bad) begin
        wr_sb.push_back({2'b00, word, 1'b0, d[15:0]});
        wr_sb.push_back({2'b00, word, 1'b1, d[31:16]});
        shadow[int'(word)] = d;
      end
    end else begin
      if (!bad) exp_rd = shadow.exists(int'(word)) ? shadow[int'(word)] : 32'h0;
      rd_sb.push_back(exp_rd);
    end
    #1;
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL %s ready_first_cycle: got %b, expected 0", name, ready);
    end
    low_cnt = 1; done = 0; strobe_bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin address = $urandom; storeValue = $urandom; end
      if (w && SRAM_OE_N !== 1'b1) strobe_bad = 1;
      if (!w && SRAM_WE_N !== 1'b1) strobe_bad = 1;
      if (ready === 1'b1) begin done = 1; break; end
      low_cnt++;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s timeout: ready never returned high", name);
    end
    checks++;
    if (low_cnt != exp_low || strobe_bad) begin
      failures++;
      $display("FAIL %s stall: ready low %0d cycles (strobe_bad=%0d), expected %0d (0)",
               name, low_cnt, strobe_bad, exp_low);
    end
    if (!w) exp_mem_data = rd_sb.pop_front();
    checks++;
    if (memoryData !== exp_mem_data) begin
      failures++;
      $display("FAIL %s memoryData: got %h, expected %h", name, memoryData, exp_mem_data);
    end
`ifdef SRAM_CTRL_RANGE_CHECK_EN
    checks++;
    if (addr_error !== bad) begin
      failures++;
      $display("FAIL %s addr_error: got %b, expected %b", name, addr_error, bad);
    end
`endif
    MEM_R_EN = 0; MEM_W_EN = 0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || SRAM_WE_N !== 1'b1 || SRAM_OE_N !== 1'b1 || SRAM_ADDR !== '0) begin
      failures++;
      $display("FAIL %s idle_after: ready=%b we_n=%b oe_n=%b addr=%0h, expected 1 1 1 0",
               name, ready, SRAM_WE_N, SRAM_OE_N, SRAM_ADDR);
    end
  endtask

  task automatic test_reset();
    rst = 1; MEM_R_EN = 0; MEM_W_EN = 0; address = 0; storeValue = 0; tb_drive = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    tb_drive = 1;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || memoryData !== 32'h0 || SRAM_WE_N !== 1'b1 || SRAM_OE_N !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: ready=%b mem=%h we_n=%b oe_n=%b, expected 1 0 1 1",
               ready, memoryData, SRAM_WE_N, SRAM_OE_N);
    end
    checks++;
    if (SRAM_DQ !== 16'h5A5A) begin
      failures++;
      $display("FAIL reset_bus_release: dq=%h, expected 5a5a from model only", SRAM_DQ);
    end
    tb_drive = 0;
  endtask

  task automatic test_write();
    do_req(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, "write_1024");
  endtask

  task automatic test_read();
    do_req(1'b1, 1'b0, 32'd1024, 32'h0, "read_1024");
    do_req(1'b1, 1'b0, 32'd1026, 32'h0, "read_1026");
  endtask

  task automatic test_write_read();
    do_req(1'b0, 1'b1, 32'd1028, 32'h12345678, "write_1028");
    do_req(1'b1, 1'b0, 32'd1028, 32'h0, "read_1028");
  endtask

  task automatic test_both_enables();
    do_req(1'b1, 1'b1, 32'd1032, 32'hA5A5A5A5, "both_en_1032");
    do_req(1'b1, 1'b0, 32'd1032, 32'h0, "read_1032");
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    MEM_R_EN = 1; address = 32'd1024;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (SRAM_ADDR !== 18'd1 || SRAM_OE_N !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_high_phase: addr=%0h oe_n=%b, expected 1 0", SRAM_ADDR, SRAM_OE_N);
    end
    rst = 1; MEM_R_EN = 0;
    @(posedge clk); #1;
    rst = 0;
    exp_mem_data = 32'h0;
    checks++;
    if (ready !== 1'b1 || memoryData !== exp_mem_data || SRAM_OE_N !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_read: ready=%b mem=%h oe_n=%b, expected 1 0 1",
               ready, memoryData, SRAM_OE_N);
    end
  endtask

`ifdef SRAM_CTRL_RANGE_CHECK_EN
  task automatic test_range_check();
    do_req(1'b1, 1'b0, 32'd1028, 32'h0, "reload_1028");
    do_req(1'b1, 1'b0, 32'd1000, 32'h0, "range_read_1000");
    do_req(1'b0, 1'b1, 32'd1000, 32'hFFFF0000, "range_write_1000");
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = 16'h0;
    exp_mem_data = 32'h0;
    test_reset();
    test_write();
    test_read();
    test_write_read();
    test_both_enables();
    test_reset_mid_read();
`ifdef SRAM_CTRL_RANGE_CHECK_EN
    test_range_check();
`endif
    repeat (2) @(negedge clk);
    checks++;
    if (wr_sb.size() != 0) begin
      failures++;
      $display("FAIL missing_writes: %0d half-word writes never strobed, expected 0", wr_sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- Multi-cycle memory-stage controller between the pipeline MEM stage and an external 16-bit asynchronous SRAM; replaces the single-cycle byte-array data memory for board builds.
- Takes one 32-bit word load/store request at a time and performs two 16-bit SRAM accesses, low half first.
- Drives `ready` low while busy so the hazard/freeze logic stalls every pipeline stage.

Parameters:
- ADDR_BASE, 1024: byte address mapped to SRAM word 0; subtracted from `address`.
- SRAM_ADDR_W, 18: SRAM half-word address width.
- ACCESS_CYCLES, 2: clock cycles each half-word access holds address/controls; legal range 1..15.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- MEM_R_EN  in  1  load request from MEM stage.
- MEM_W_EN  in  1  store request from MEM stage.
- address  in  32  byte address of the word.
- storeValue  in  32  store data.
- memoryData  out  32  load result, registered.
- ready  out  1  1 = no stall required this cycle.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  out  SRAM_ADDR_W  half-word address.
- SRAM_WE_N  out  1  write strobe, active low.
- SRAM_OE_N  out  1  output enable, active low.
- SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  tied 0 (chip and both byte lanes always enabled).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Address translation:
  - off = address - ADDR_BASE (32-bit wrap).
  - word = off[SRAM_ADDR_W:2]; off[1:0] ignored (word-aligned access).
  - Low half is at SRAM_ADDR = {word, 1'b0}; high half is at SRAM_ADDR = {word, 1'b1}.
- Request: req = MEM_R_EN | MEM_W_EN.
  - If both enables are high, the request is a write; the read is dropped.
- Request latching: address, storeValue and the read/write kind are captured in the IDLE cycle that sees req. Later input changes are ignored until DONE.
- States: IDLE, LOW, HIGH, DONE.
  - IDLE: req goes to LOW with the phase counter set to 0; no req stays in IDLE.
  - LOW: hold low-half address and controls for ACCESS_CYCLES cycles. When the counter reaches ACCESS_CYCLES-1, move to HIGH and set the counter to 0.
  - HIGH: same as LOW for the high half, then go to DONE.
  - DONE: one cycle, then unconditionally back to IDLE.
- ready (combinational): ready = (IDLE & ~req) | DONE.
  - ready drops in the same cycle a request appears, so the request is stalled from its first cycle.
  - The pipeline advances on the DONE edge, so the request is consumed exactly once.
- Latency: ready stays low for exactly 1 + 2*ACCESS_CYCLES cycles; with default ACCESS_CYCLES=2 that is 5 cycles, and DONE is the 6th cycle of the request.
- Write sequence:
  - SRAM_DQ drives storeValue[15:0] in LOW and storeValue[31:16] in HIGH.
  - SRAM_WE_N = 0 in every phase cycle except the last one of each phase, giving data hold time with address stable.
  - With ACCESS_CYCLES=1, SRAM_WE_N = 0 for the whole cycle.
  - SRAM_OE_N = 1 throughout a write.
- Read sequence:
  - SRAM_OE_N = 0 in LOW and HIGH; SRAM_DQ is high-Z.
  - SRAM_DQ is sampled on the last cycle of each phase: LOW fills bits [15:0], HIGH fills bits [31:16].
  - memoryData updates on entry to DONE and holds until the next completed read. Writes never change it.
- Idle bus: in IDLE and DONE, SRAM_WE_N = 1, SRAM_OE_N = 1, SRAM_DQ is high-Z, SRAM_ADDR = 0.
- Reset values: state IDLE, counter 0, memoryData = 0, SRAM_WE_N = 1, SRAM_OE_N = 1, SRAM_DQ high-Z.
  - ready therefore reads 1 after reset if req = 0.
- Reset mid-operation aborts immediately. A partial write may leave one SRAM half updated; this is acceptable.

Optional Feature:
- SRAM_CTRL_RANGE_CHECK_EN defined:
  - Adds output port addr_error (1 bit, reset 0).
  - Condition: address < ADDR_BASE, or word >= 2**(SRAM_ADDR_W-1).
  - In IDLE with req and this condition, go directly to DONE with no SRAM strobes; the request completes with ready low for 1 cycle only.
  - For a read, memoryData = 0.
  - addr_error = 1 only in that DONE cycle.
- Undefined: no port and no check; the address wraps silently into the SRAM.

Test Plan:
- Reset, then no request -> ready=1, memoryData=0, SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ high-Z.
- Write address=1024, storeValue=0xDEADBEEF, ACCESS_CYCLES=2 -> SRAM_ADDR=0 with DQ=0xBEEF, then SRAM_ADDR=1 with DQ=0xDEAD; WE_N low 1 cycle per half; ready low exactly 5 cycles, high in DONE.
- Read address=1024 after that write, SRAM model returning the stored halves -> memoryData=0xDEADBEEF in DONE; address=1026 also reads word 0.
- Write address=1028, value 0x12345678, then read 1028 -> memoryData=0x12345678; in the intervening write, memoryData keeps its previous value.
- MEM_R_EN and MEM_W_EN both 1, address 1032, value 0xA5A5A5A5 -> write performed, OE_N stays 1, memoryData unchanged.
- Assert rst during HIGH of a read -> next cycle IDLE, ready=1, memoryData=0; with SRAM_CTRL_RANGE_CHECK_EN, read address=1000 -> addr_error=1 for one cycle, ready low 1 cycle, no SRAM strobe.
